// File: rtl/hex_digit_scanner_if.sv
// Host-side and display-side signals of the hex digit scanner.
// The host drives load/value_in/blank_lz; the scanner drives the digit outputs.
interface hex_digit_scanner_if #(
  parameter int DIGITS = 4
);
  logic                  load;
  logic [4*DIGITS-1:0]   value_in;
  logic                  blank_lz;
  logic [3:0]            nibble_out;
  logic [DIGITS-1:0]     an_n;
  logic                  digit_tick;

  modport master (
    output load, value_in, blank_lz,
    input  nibble_out, an_n, digit_tick
  );

  modport slave (
    input  load, value_in, blank_lz,
    output nibble_out, an_n, digit_tick
  );
endinterface

// File: rtl/hex_digit_scanner.sv
// Time-multiplexed scan controller for a common-anode hex display. New values are
// captured on load and only swapped into the displayed register at a frame boundary.
module hex_digit_scanner #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50000,
  parameter int PW       = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  hex_digit_scanner_if.slave    bus
);
  localparam int             IW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0]  PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [IW-1:0]  IDX_LAST = IW'(DIGITS - 1);

  logic [PW-1:0]        pre;
  logic [IW-1:0]        idx;
  logic [4*DIGITS-1:0]  shadow;
  logic [4*DIGITS-1:0]  disp;
  logic                 pend;
  logic                 lz_q;

  logic                 tick;
  logic                 fb;
  logic [DIGITS-1:0]    zero_from;
  logic                 blank;
  logic [DIGITS-1:0]    an_n_c;

  assign tick = (pre == PRE_LAST);
  assign fb   = tick && (idx == IDX_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      pre    <= '0;
      idx    <= '0;
      shadow <= '0;
      disp   <= '0;
      pend   <= 1'b0;
      lz_q   <= 1'b0;
    end else begin
      pre <= tick ? '0 : pre + 1'b1;
      if (tick)
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      if (bus.load)
        shadow <= bus.value_in;
      if (fb) begin
        lz_q <= bus.blank_lz;
        pend <= 1'b0;
        // a load landing on the boundary bypasses the shadow wait
        if (bus.load)
          disp <= bus.value_in;
        else if (pend)
          disp <= shadow;
      end else if (bus.load) begin
        pend <= 1'b1;
      end
    end
  end

  // zero_from[k]: every nibble from the top down to k is zero
  always_comb begin
    logic all_zero;
    all_zero  = 1'b1;
    zero_from = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      all_zero     = all_zero & (disp[4*k +: 4] == 4'h0);
      zero_from[k] = all_zero;
    end
  end

  assign blank = lz_q && (idx != '0) && zero_from[idx];

  always_comb begin
    an_n_c = '1;
    if (!blank)
      an_n_c[idx] = 1'b0;
  end

  assign bus.nibble_out = disp[{idx, 2'b00} +: 4];
  assign bus.an_n       = an_n_c;
  assign bus.digit_tick = tick;
endmodule

// File: tb/tb_hex_digit_scanner.sv
// Directed bench for hex_digit_scanner with DIGITS=4, PRESCALE=4.
module tb_hex_digit_scanner;
  localparam int DIGITS   = 4;
  localparam int PRESCALE = 4;
  localparam int PW       = 3;

  logic clk;
  logic reset;
  int   c;
  int   n_checks;
  int   n_fail;

  hex_digit_scanner_if #(.DIGITS(DIGITS)) bus ();

  hex_digit_scanner #(.DIGITS(DIGITS), .PRESCALE(PRESCALE), .PW(PW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // c counts edges since reset release; c%16 = idx*4 + pre
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    c = c + 1;
  endtask

  task automatic go_to(input int pos);
    for (int i = 0; i < 16; i++) begin
      if (c % 16 == pos) break;
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.load = 1'b0;
    bus.value_in = '0;
    bus.blank_lz = 1'b0;
    step();
    step();
    reset = 1'b0;
    c = 0;
    n_checks++;
    if (bus.nibble_out !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_nibble: got %h want 0", bus.nibble_out);
    end
    n_checks++;
    if (bus.an_n !== 4'b1110) begin
      n_fail++;
      $display("FAIL reset_an_n: got %b want 1110", bus.an_n);
    end
    n_checks++;
    if (bus.digit_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_tick: got %b want 0", bus.digit_tick);
    end
  endtask

  task automatic test_idle_scan();
    logic [3:0] exp_an;
    for (int k = 0; k < 32; k++) begin
      exp_an = ~(4'b0001 << ((k / 4) % 4));
      n_checks++;
      if (bus.an_n !== exp_an) begin
        n_fail++;
        $display("FAIL idle_an_n cyc %0d: got %b want %b", k, bus.an_n, exp_an);
      end
      n_checks++;
      if (bus.nibble_out !== 4'h0) begin
        n_fail++;
        $display("FAIL idle_nibble cyc %0d: got %h want 0", k, bus.nibble_out);
      end
      n_checks++;
      if (bus.digit_tick !== (k % 4 == 3)) begin
        n_fail++;
        $display("FAIL idle_tick cyc %0d: got %b want %b", k, bus.digit_tick, (k % 4 == 3));
      end
      step();
    end
  endtask

  task automatic test_load_frame();
    logic [15:0] v;
    v = 16'hA3C5;
    go_to(4);
    bus.load = 1'b1;
    bus.value_in = v;
    step();
    bus.load = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (c % 16 == 0) break;
      n_checks++;
      if (bus.nibble_out !== 4'h0) begin
        n_fail++;
        $display("FAIL load_early_nibble pos %0d: got %h want 0", c % 16, bus.nibble_out);
      end
      step();
    end
    for (int d = 0; d < 4; d++) begin
      n_checks++;
      if (bus.nibble_out !== v[4*d +: 4]) begin
        n_fail++;
        $display("FAIL load_nibble d%0d: got %h want %h", d, bus.nibble_out, v[4*d +: 4]);
      end
      n_checks++;
      if (bus.an_n !== ~(4'b0001 << d)) begin
        n_fail++;
        $display("FAIL load_an_n d%0d: got %b want %b", d, bus.an_n, ~(4'b0001 << d));
      end
      repeat (4) step();
    end
  endtask

  task automatic test_blank_lz();
    logic [3:0] an_a [4];
    logic [3:0] nib_a [4];
    logic [3:0] an_b [4];
    an_a  = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
    nib_a = '{4'h0, 4'h7, 4'h0, 4'h0};
    an_b  = '{4'b1110, 4'b1111, 4'b1111, 4'b1111};
    bus.blank_lz = 1'b1;
    bus.load = 1'b1;
    bus.value_in = 16'h0070;
    step();
    bus.load = 1'b0;
    go_to(0);
    for (int d = 0; d < 4; d++) begin
      n_checks++;
      if (bus.nibble_out !== nib_a[d]) begin
        n_fail++;
        $display("FAIL blank70_nibble d%0d: got %h want %h", d, bus.nibble_out, nib_a[d]);
      end
      n_checks++;
      if (bus.an_n !== an_a[d]) begin
        n_fail++;
        $display("FAIL blank70_an_n d%0d: got %b want %b", d, bus.an_n, an_a[d]);
      end
      repeat (4) step();
    end
    bus.load = 1'b1;
    bus.value_in = 16'h0000;
    step();
    bus.load = 1'b0;
    go_to(0);
    for (int d = 0; d < 4; d++) begin
      n_checks++;
      if (bus.nibble_out !== 4'h0) begin
        n_fail++;
        $display("FAIL blank00_nibble d%0d: got %h want 0", d, bus.nibble_out);
      end
      n_checks++;
      if (bus.an_n !== an_b[d]) begin
        n_fail++;
        $display("FAIL blank00_an_n d%0d: got %b want %b", d, bus.an_n, an_b[d]);
      end
      repeat (4) step();
    end
  endtask

  task automatic test_back_to_back();
    bus.blank_lz = 1'b0;
    bus.load = 1'b1;
    bus.value_in = 16'h1111;
    step();
    bus.load = 1'b0;
    go_to(8);
    bus.load = 1'b1;
    bus.value_in = 16'h2222;
    step();
    bus.load = 1'b0;
    go_to(0);
    for (int k = 0; k < 16; k++) begin
      n_checks++;
      if (bus.nibble_out !== 4'h2) begin
        n_fail++;
        $display("FAIL b2b_nibble pos %0d: got %h want 2", k, bus.nibble_out);
      end
      n_checks++;
      if (bus.an_n !== ~(4'b0001 << (k / 4))) begin
        n_fail++;
        $display("FAIL b2b_an_n pos %0d: got %b want %b", k, bus.an_n, ~(4'b0001 << (k / 4)));
      end
      step();
    end
  endtask

  task automatic test_load_on_fb();
    logic [15:0] v;
    v = 16'hBEEF;
    go_to(15);
    bus.load = 1'b1;
    bus.value_in = v;
    step();
    bus.load = 1'b0;
    n_checks++;
    if (dut.pend !== 1'b0) begin
      n_fail++;
      $display("FAIL fbload_pend: got %b want 0", dut.pend);
    end
    for (int d = 0; d < 4; d++) begin
      n_checks++;
      if (bus.nibble_out !== v[4*d +: 4]) begin
        n_fail++;
        $display("FAIL fbload_nibble d%0d: got %h want %h", d, bus.nibble_out, v[4*d +: 4]);
      end
      n_checks++;
      if (bus.an_n !== ~(4'b0001 << d)) begin
        n_fail++;
        $display("FAIL fbload_an_n d%0d: got %b want %b", d, bus.an_n, ~(4'b0001 << d));
      end
      repeat (4) step();
    end
  endtask

  task automatic test_mid_reset();
    bus.load = 1'b1;
    bus.value_in = 16'h1234;
    step();
    bus.load = 1'b0;
    n_checks++;
    if (dut.pend !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_pend_before: got %b want 1", dut.pend);
    end
    go_to(9);
    reset = 1'b1;
    step();
    reset = 1'b0;
    c = 0;
    n_checks++;
    if (bus.nibble_out !== 4'h0) begin
      n_fail++;
      $display("FAIL midrst_nibble: got %h want 0", bus.nibble_out);
    end
    n_checks++;
    if (bus.an_n !== 4'b1110) begin
      n_fail++;
      $display("FAIL midrst_an_n: got %b want 1110", bus.an_n);
    end
    n_checks++;
    if (bus.digit_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_tick: got %b want 0", bus.digit_tick);
    end
    n_checks++;
    if (dut.pend !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_pend_after: got %b want 0", dut.pend);
    end
    for (int k = 0; k < 36; k++) begin
      n_checks++;
      if (bus.nibble_out !== 4'h0) begin
        n_fail++;
        $display("FAIL midrst_stale cyc %0d: got %h want 0", k, bus.nibble_out);
      end
      step();
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    c        = 0;
    test_reset();
    test_idle_scan();
    test_load_frame();
    test_blank_lz();
    test_back_to_back();
    test_load_on_fb();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
